// File: rtl/uart_cmd_parser.sv
// Framed host-command decoder: A5 | CMD | ADDR_H | ADDR_L | LEN | payload | CSUM.
// Drives sample RAM writes, the DDS tuning word and the run flag; answers each frame with ACK/NAK.
module uart_cmd_parser #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        from_uart_data,
    input  logic              from_uart_valid,
    input  logic              from_uart_error,
    output logic              from_uart_ready,
    output logic [7:0]        to_uart_data,
    output logic              to_uart_valid,
    output logic              to_uart_error,
    input  logic              to_uart_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [31:0]       ftw,
    output logic              ftw_update,
    output logic              run
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] Sof = 8'hA5;
    localparam logic [7:0] Ack = 8'h06;
    localparam logic [7:0] Nak = 8'h15;
    localparam logic [1:0] CmdWrite = 2'd1;
    localparam logic [1:0] CmdFtw   = 2'd2;
    localparam logic [1:0] CmdRun   = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddrH, StAddrL, StLen, StPayload, StCsum, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [7:0]        resp_q, resp_d;
    logic              tx_valid_q, tx_valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [31:0]       ftw_q, ftw_d;
    logic              upd_q, upd_d;
    logic              run_q, run_d;

    logic accept, in_frame, ack, nak, len_ok;

    assign from_uart_ready = (state_q != StResp);
    assign accept          = from_uart_valid & from_uart_ready;
    assign in_frame        = (state_q != StIdle) && (state_q != StResp);
    assign len_ok          = (cmd_q == CmdWrite) ||
                             ((cmd_q == CmdFtw) && (from_uart_data == 8'd4)) ||
                             ((cmd_q == CmdRun) && (from_uart_data == 8'd1));

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        shadow_d   = shadow_q;
        resp_d     = resp_q;
        tx_valid_d = tx_valid_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        ftw_d      = ftw_q;
        upd_d      = 1'b0;
        run_d      = run_q;
        ack        = 1'b0;
        nak        = 1'b0;
        tmo_d      = '0;

        // Idle gap counter; cleared by every accepted byte inside a frame.
        if (in_frame && !accept) begin
            tmo_d = tmo_q + TmoW'(1);
            if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) nak = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && !from_uart_error && from_uart_data == Sof) state_d = StCmd;
            end
            StCmd: begin
                if (accept) begin
                    if (from_uart_error || from_uart_data == 8'h00 || from_uart_data > 8'h03) begin
                        nak = 1'b1;
                    end else begin
                        cmd_d   = from_uart_data[1:0];
                        csum_d  = from_uart_data;
                        state_d = StAddrH;
                    end
                end
            end
            StAddrH: begin
                if (accept) begin
                    if (from_uart_error) begin
                        nak = 1'b1;
                    end else begin
                        ptr_d   = ADDR_W'({from_uart_data, 8'h00});
                        csum_d  = csum_q ^ from_uart_data;
                        state_d = StAddrL;
                    end
                end
            end
            StAddrL: begin
                if (accept) begin
                    if (from_uart_error) begin
                        nak = 1'b1;
                    end else begin
                        ptr_d   = ptr_q | ADDR_W'(from_uart_data);
                        csum_d  = csum_q ^ from_uart_data;
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                if (accept) begin
                    if (from_uart_error || !len_ok) begin
                        nak = 1'b1;
                    end else begin
                        cnt_d   = (from_uart_data == 8'd0) ? 9'd256 : {1'b0, from_uart_data};
                        csum_d  = csum_q ^ from_uart_data;
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    if (from_uart_error) begin
                        nak = 1'b1;
                    end else begin
                        csum_d   = csum_q ^ from_uart_data;
                        shadow_d = {shadow_q[23:0], from_uart_data};
                        cnt_d    = cnt_q - 9'd1;
                        if (cmd_q == CmdWrite) begin
                            we_d    = 1'b1;
                            waddr_d = ptr_q;
                            wdata_d = from_uart_data;
                            ptr_d   = ptr_q + ADDR_W'(1);
                        end
                        if (cnt_q == 9'd1) state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (from_uart_error || from_uart_data != csum_q) begin
                        nak = 1'b1;
                    end else begin
                        ack = 1'b1;
                        if (cmd_q == CmdFtw) begin
                            ftw_d = shadow_q;
                            upd_d = 1'b1;
                        end
                        if (cmd_q == CmdRun) run_d = shadow_q[0];
                    end
                end
            end
            StResp: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (to_uart_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ack || nak) begin
            state_d = StResp;
            resp_d  = ack ? Ack : Nak;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            shadow_q   <= '0;
            tmo_q      <= '0;
            resp_q     <= '0;
            tx_valid_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            ftw_q      <= '0;
            upd_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            shadow_q   <= shadow_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            tx_valid_q <= tx_valid_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            ftw_q      <= ftw_d;
            upd_q      <= upd_d;
            run_q      <= run_d;
        end
    end

    assign to_uart_data  = resp_q;
    assign to_uart_valid = tx_valid_q;
    assign to_uart_error = 1'b0;
    assign mem_we        = we_q;
    assign mem_addr      = waddr_q;
    assign mem_wdata     = wdata_q;
    assign ftw           = ftw_q;
    assign ftw_update    = upd_q;
    assign run           = run_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised frame-level bench for uart_cmd_parser; expectations come from a frame-rule model.
module tb_uart_cmd_parser;
    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 64;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    from_uart_data = '0;
    logic          from_uart_valid = 1'b0;
    logic          from_uart_error = 1'b0;
    logic          from_uart_ready;
    logic [7:0]    to_uart_data;
    logic          to_uart_valid;
    logic          to_uart_error;
    logic          to_uart_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [31:0]   ftw;
    logic          ftw_update;
    logic          run;

    uart_cmd_parser #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .from_uart_data  (from_uart_data),
        .from_uart_valid (from_uart_valid),
        .from_uart_error (from_uart_error),
        .from_uart_ready (from_uart_ready),
        .to_uart_data    (to_uart_data),
        .to_uart_valid   (to_uart_valid),
        .to_uart_error   (to_uart_error),
        .to_uart_ready   (to_uart_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .ftw             (ftw),
        .ftw_update      (ftw_update),
        .run             (run)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  resp_q[$];
    logic [19:0] wr_q[$];
    int          upd_cnt = 0;
    bit          rdy_hold = 1'b0;
    logic [7:0]  pl[$];
    logic [31:0] exp_ftw = '0;
    logic        exp_run = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response sink with random back-pressure; also records RAM writes and ftw pulses.
    always @(negedge clk) begin
        logic r;
        r = !rdy_hold && ($urandom_range(0, 3) != 0);
        to_uart_ready = r;
        if (rst_n && to_uart_valid && r) resp_q.push_back(to_uart_data);
        if (rst_n && mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (rst_n && ftw_update) upd_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!from_uart_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!from_uart_ready) check("rx_ready_wait", 32'(from_uart_ready), 32'd1);
        from_uart_data  = b;
        from_uart_error = e;
        from_uart_valid = 1'b1;
        @(negedge clk);
        from_uart_valid = 1'b0;
        from_uart_error = 1'b0;
    endtask

    task automatic wait_resp(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (resp_q.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check({tag, "_resp_count"}, 32'(resp_q.size()), 32'd1);
        if (resp_q.size() > 0) check({tag, "_resp"}, 32'(resp_q[0]), 32'(exp));
    endtask

    // Frame model: decides where the frame ends, what reply is due and which effects apply.
    task automatic exec_frame(input string tag, input logic [7:0] cmd, input logic [15:0] addr,
                              input logic [7:0] len, input bit bad_cs, input int err_at,
                              input int extra);
        logic [7:0]    fr[$];
        logic [19:0]   exp_wr[$];
        logic [7:0]    cs, g, exp_resp;
        logic [AW-1:0] a;
        int            stop, base, exp_upd;
        bit            ok_cmd, ok_len;
        fr = {8'hA5, cmd, addr[15:8], addr[7:0], len};
        cs = cmd ^ addr[15:8] ^ addr[7:0] ^ len;
        foreach (pl[i]) begin
            fr.push_back(pl[i]);
            cs = cs ^ pl[i];
        end
        if (bad_cs) cs = cs ^ 8'h5A;
        fr.push_back(cs);
        ok_cmd   = cmd inside {8'h01, 8'h02, 8'h03};
        ok_len   = (cmd == 8'h01) || (cmd == 8'h02 && len == 8'd4) || (cmd == 8'h03 && len == 8'd1);
        stop     = fr.size() - 1;
        exp_resp = bad_cs ? NAK : ACK;
        if (!ok_cmd) begin
            stop = 1;
            exp_resp = NAK;
        end else if (!ok_len) begin
            stop = 4;
            exp_resp = NAK;
        end
        if (err_at > 0 && err_at <= stop) begin
            stop = err_at;
            exp_resp = NAK;
        end
        if (cmd == 8'h01) begin
            foreach (pl[i]) begin
                if (5 + i < stop) begin
                    a = addr[AW-1:0] + AW'(i);
                    exp_wr.push_back({a, pl[i]});
                end
            end
        end
        exp_upd = 0;
        if (exp_resp == ACK && cmd == 8'h02) begin
            exp_ftw = {pl[0], pl[1], pl[2], pl[3]};
            exp_upd = 1;
        end
        if (exp_resp == ACK && cmd == 8'h03) exp_run = pl[0][0];

        wr_q.delete();
        resp_q.delete();
        base = upd_cnt;
        for (int i = 0; i <= stop; i++) send_byte(fr[i], i == err_at);
        for (int i = 0; i < extra; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1'b0);
        end
        wait_resp(exp_resp, tag);
        check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        foreach (exp_wr[i]) begin
            if (i < wr_q.size()) check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
        end
        check({tag, "_ftw"}, ftw, exp_ftw);
        check({tag, "_run"}, 32'(run), 32'(exp_run));
        check({tag, "_upd"}, 32'(upd_cnt - base), 32'(exp_upd));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(from_uart_ready), 32'd1);
        check({tag, "_tx_valid"}, 32'(to_uart_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(to_uart_data), 32'd0);
        check({tag, "_tx_error"}, 32'(to_uart_error), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_ftw"}, ftw, 32'd0);
        check({tag, "_ftw_update"}, 32'(ftw_update), 32'd0);
        check({tag, "_run"}, 32'(run), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, nlen, err_at, extra, n;
        logic [7:0]  cmd, len, d0;
        logic [15:0] addr;
        bit          bad_cs, stable;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pl = {8'h11, 8'h22, 8'h33};
        exec_frame("wr_ex", 8'h01, 16'h0010, 8'd3, 1'b0, -1, 0);
        pl = {8'hC3, 8'h3C};
        exec_frame("wrap", 8'h01, 16'h0FFF, 8'd2, 1'b0, -1, 0);
        pl = {8'h12, 8'h34, 8'h56, 8'h78};
        exec_frame("ftw_ex", 8'h02, 16'h0000, 8'd4, 1'b0, -1, 0);
        pl = {8'h01};
        exec_frame("run_badcs", 8'h03, 16'h0000, 8'd1, 1'b1, -1, 0);
        pl = {8'h01};
        exec_frame("bad_cmd", 8'h07, 16'h0000, 8'd1, 1'b0, -1, 4);

        // Stall after LEN: reply must not come early, then NAK.
        resp_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        repeat (TMO - 4) @(negedge clk);
        check("tmo_early", 32'(to_uart_valid), 32'd0);
        wait_resp(NAK, "tmo");
        check("tmo_ftw", ftw, exp_ftw);

        // Back-pressure: reply held while the sink stalls.
        rdy_hold = 1'b1;
        resp_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        n = 0;
        while (!to_uart_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        d0 = to_uart_data;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(to_uart_valid && to_uart_data == d0 && !from_uart_ready)) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_data", 32'(d0), 32'(ACK));
        check("hold_run", 32'(run), 32'd1);
        exp_run = 1'b1;
        rdy_hold = 1'b0;
        wait_resp(ACK, "hold");

        // Reset in the middle of a WRITE_MEM payload.
        resp_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_noresp", 32'(resp_q.size()), 32'd0);
        check("midrst_idle_ready", 32'(from_uart_ready), 32'd1);
        exp_ftw = '0;
        exp_run = 1'b0;

        for (int f = 0; f < 40; f++) begin
            kind   = $urandom_range(0, 8);
            err_at = -1;
            extra  = 0;
            addr   = 16'($urandom_range(0, 65535));
            cmd    = 8'h01;
            len    = 8'd1;
            case (kind)
                0, 1: begin
                    cmd = 8'h01;
                    len = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
                end
                2, 3: begin
                    cmd = 8'h02;
                    len = 8'd4;
                end
                4, 5: begin
                    cmd = 8'h03;
                    len = 8'd1;
                end
                6: begin
                    cmd = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
                    extra = 3;
                end
                7: begin
                    cmd = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
                    len = 8'($urandom_range(0, 255));
                    if ((cmd == 8'h02 && len == 8'd4) || (cmd == 8'h03 && len == 8'd1))
                        len = len ^ 8'h80;
                end
                default: begin
                    cmd = 8'($urandom_range(1, 3));
                    len = (cmd == 8'h01) ? 8'($urandom_range(1, 8)) :
                          (cmd == 8'h02) ? 8'd4 : 8'd1;
                end
            endcase
            nlen = (len == 8'd0) ? 256 : int'(len);
            if (kind == 7) nlen = 4;
            pl.delete();
            for (int i = 0; i < nlen; i++) pl.push_back(8'($urandom_range(0, 255)));
            bad_cs = (kind == 1 || kind == 3 || kind == 5);
            if (kind == 8) err_at = $urandom_range(1, 5 + nlen);
            exec_frame("rnd", cmd, addr, len, bad_cs, err_at, extra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
